// File: rtl/paicore_send_pkg.sv
// Shared definitions for the PAICORE send-path job scheduler.
// Holds the state encoding and the C0/C1 beat-split helper.
package paicore_send_pkg;

  localparam int LEN_W_DEF = 32;
  localparam int SPLIT_W   = 64;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_RUN   = 3'd2;
  localparam logic [2:0] ST_DONE  = 3'd3;
  localparam logic [2:0] ST_ERR   = 3'd4;

  typedef struct packed {
    logic [SPLIT_W-1:0] c0;
    logic [SPLIT_W-1:0] c1;
  } len_split_t;

  // The odd remainder goes to C0; the rounding add is one bit wider so all-ones cannot wrap.
  function automatic len_split_t split_len(input logic [SPLIT_W-1:0] len, input logic fork_en);
    len_split_t res;
    logic [SPLIT_W:0] half_up;
    half_up = ({1'b0, len} + {{SPLIT_W{1'b0}}, 1'b1}) >> 1'b1;
    if (fork_en) begin
      res.c0 = half_up[SPLIT_W-1:0];
      res.c1 = len >> 1'b1;
    end else begin
      res.c0 = len;
      res.c1 = {SPLIT_W{1'b0}};
    end
    return res;
  endfunction

endpackage

// File: rtl/paicore_send_sched_watchdog.sv
// Per-job stall watchdog: counts idle cycles and flags expiry on the cycle
// the count reaches TIMEOUT_CYCLES.
module send_watchdog #(
  parameter int              TO_W           = 24,
  parameter logic [TO_W-1:0] TIMEOUT_CYCLES = 24'hFFFFFF
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic tick,
  output logic expired
);

  localparam logic [TO_W-1:0] LAST_CNT = TIMEOUT_CYCLES - {{(TO_W-1){1'b0}}, 1'b1};

  logic [TO_W-1:0] cnt_r;

  // Idle-cycle counter, restarted on any activity or outside a running job.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {TO_W{1'b0}};
    end else if (clear) begin
      cnt_r <= {TO_W{1'b0}};
    end else if (tick) begin
      cnt_r <= cnt_r + {{(TO_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign expired = tick & ~clear & (cnt_r == LAST_CNT);

endmodule

// File: rtl/paicore_send_sched.sv
// Job-level controller for the two-channel send path: accepts a command,
// splits beats across C0/C1, tracks progress and reports completion/errors.
module paicore_send_sched
  import paicore_send_pkg::*;
#(
  parameter int              LEN_W          = LEN_W_DEF,
  parameter int              TO_W           = 24,
  parameter logic [TO_W-1:0] TIMEOUT_CYCLES = 24'hFFFFFF
) (
  input  logic             s_axis_aclk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             cmd_fork,
  output logic             fork_enable,
  output logic [LEN_W-1:0] len_c0,
  output logic [LEN_W-1:0] len_c1,
  output logic             ch_start,
  input  logic             beat_c0,
  input  logic             beat_c1,
  input  logic             done_c0,
  input  logic             done_c1,
  input  logic             abort,
  output logic             busy,
  output logic             tx_done,
  output logic [LEN_W-1:0] cnt_c0,
  output logic [LEN_W-1:0] cnt_c1,
  output logic             err_timeout,
  output logic             err_count,
  output logic             aborted
);

  localparam logic [LEN_W-1:0] CNT_ONE = {{(LEN_W-1){1'b0}}, 1'b1};
  localparam logic [LEN_W-1:0] CNT_MAX = {LEN_W{1'b1}};

  logic [2:0]         state_r;
  logic [2:0]         next_state_s;
  logic               done_seen_c0_r;
  logic               done_seen_c1_r;
  logic               all_done_s;
  logic               activity_s;
  logic               wd_clear_s;
  logic               wd_tick_s;
  logic               wd_expired_s;
  logic [SPLIT_W-1:0] len_ext_s;
  len_split_t         split_s;

  assign activity_s = beat_c0 | beat_c1 | done_c0 | done_c1;
  assign all_done_s = (done_seen_c0_r | done_c0) & (done_seen_c1_r | done_c1);
  assign wd_clear_s = (state_r != ST_RUN) | activity_s;
  assign wd_tick_s  = (state_r == ST_RUN) & ~activity_s;

  // Zero-extend the command length so the shared split helper works for any LEN_W.
  always_comb begin
    len_ext_s              = {SPLIT_W{1'b0}};
    len_ext_s[LEN_W-1:0]   = cmd_len;
    split_s                = split_len(len_ext_s, cmd_fork);
  end

  send_watchdog #(
    .TO_W           (TO_W),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (s_axis_aclk),
    .rst     (rst),
    .clear   (wd_clear_s),
    .tick    (wd_tick_s),
    .expired (wd_expired_s)
  );

  // Next-state logic; within RUN, abort beats completion which beats timeout.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (cmd_valid) begin
          if (cmd_len == {LEN_W{1'b0}}) begin
            next_state_s = ST_DONE;
          end else begin
            next_state_s = ST_START;
          end
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (abort) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_RUN;
        end
      end
      ST_RUN: begin
        if (abort) begin
          next_state_s = ST_IDLE;
        end else if (all_done_s) begin
          next_state_s = ST_DONE;
        end else if (wd_expired_s) begin
          next_state_s = ST_ERR;
        end else begin
          next_state_s = ST_RUN;
        end
      end
      ST_DONE: next_state_s = ST_IDLE;
      ST_ERR:  next_state_s = ST_IDLE;
      default: next_state_s = ST_IDLE;
    endcase
  end

  // State, job bookkeeping and all registered outputs.
  always_ff @(posedge s_axis_aclk) begin
    if (rst) begin
      state_r        <= ST_IDLE;
      cmd_ready      <= 1'b1;
      busy           <= 1'b0;
      ch_start       <= 1'b0;
      tx_done        <= 1'b0;
      fork_enable    <= 1'b0;
      len_c0         <= {LEN_W{1'b0}};
      len_c1         <= {LEN_W{1'b0}};
      cnt_c0         <= {LEN_W{1'b0}};
      cnt_c1         <= {LEN_W{1'b0}};
      err_timeout    <= 1'b0;
      err_count      <= 1'b0;
      aborted        <= 1'b0;
      done_seen_c0_r <= 1'b0;
      done_seen_c1_r <= 1'b0;
    end else begin
      state_r   <= next_state_s;
      cmd_ready <= (next_state_s == ST_IDLE);
      busy      <= (next_state_s != ST_IDLE);
      ch_start  <= (next_state_s == ST_START);
      tx_done   <= (next_state_s == ST_DONE);
      case (state_r)
        ST_IDLE: begin
          if (cmd_valid) begin
            fork_enable    <= cmd_fork;
            len_c0         <= split_s.c0[LEN_W-1:0];
            len_c1         <= split_s.c1[LEN_W-1:0];
            cnt_c0         <= {LEN_W{1'b0}};
            cnt_c1         <= {LEN_W{1'b0}};
            err_timeout    <= 1'b0;
            err_count      <= 1'b0;
            aborted        <= 1'b0;
            done_seen_c0_r <= 1'b0;
            done_seen_c1_r <= 1'b0;
          end
        end
        ST_START: begin
          // A channel with nothing to send is treated as already finished.
          done_seen_c0_r <= (len_c0 == {LEN_W{1'b0}});
          done_seen_c1_r <= (len_c1 == {LEN_W{1'b0}});
          if (abort) begin
            aborted <= 1'b1;
          end
        end
        ST_RUN: begin
          if (beat_c0 && (cnt_c0 != CNT_MAX)) begin
            cnt_c0 <= cnt_c0 + CNT_ONE;
          end
          if (beat_c1 && (cnt_c1 != CNT_MAX)) begin
            cnt_c1 <= cnt_c1 + CNT_ONE;
          end
          if (done_c0) begin
            done_seen_c0_r <= 1'b1;
          end
          if (done_c1) begin
            done_seen_c1_r <= 1'b1;
          end
          if (abort) begin
            aborted <= 1'b1;
          end
        end
        ST_DONE: begin
          err_count <= (cnt_c0 != len_c0) | (cnt_c1 != len_c1);
        end
        ST_ERR: begin
          err_timeout <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_paicore_send_sched.sv
// Self-checking bench for paicore_send_sched: a reference split model and a
// scoreboard of per-job end results, compared when each job retires.
module tb_paicore_send_sched;

  localparam int LEN_W = 32;

  logic             clk;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [LEN_W-1:0] cmd_len;
  logic             cmd_fork;
  logic             fork_enable;
  logic [LEN_W-1:0] len_c0;
  logic [LEN_W-1:0] len_c1;
  logic             ch_start;
  logic             beat_c0;
  logic             beat_c1;
  logic             done_c0;
  logic             done_c1;
  logic             abort;
  logic             busy;
  logic             tx_done;
  logic [LEN_W-1:0] cnt_c0;
  logic [LEN_W-1:0] cnt_c1;
  logic             err_timeout;
  logic             err_count;
  logic             aborted;

  paicore_send_sched #(
    .LEN_W          (LEN_W),
    .TO_W           (24),
    .TIMEOUT_CYCLES (24'd16)
  ) dut (
    .s_axis_aclk (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_len     (cmd_len),
    .cmd_fork    (cmd_fork),
    .fork_enable (fork_enable),
    .len_c0      (len_c0),
    .len_c1      (len_c1),
    .ch_start    (ch_start),
    .beat_c0     (beat_c0),
    .beat_c1     (beat_c1),
    .done_c0     (done_c0),
    .done_c1     (done_c1),
    .abort       (abort),
    .busy        (busy),
    .tx_done     (tx_done),
    .cnt_c0      (cnt_c0),
    .cnt_c1      (cnt_c1),
    .err_timeout (err_timeout),
    .err_count   (err_count),
    .aborted     (aborted)
  );

  typedef struct {
    int          txd;
    logic        err_count;
    logic        err_timeout;
    logic        aborted;
    logic [31:0] cnt0;
    logic [31:0] cnt1;
  } exp_t;

  exp_t        sb_q[$];
  int          n_vec;
  int          n_err;
  int          txd_total;
  int          txd_base;
  logic [31:0] mdl_c0;
  logic [31:0] mdl_c1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count every tx_done pulse, sampled mid-cycle.
  initial txd_total = 0;
  always @(negedge clk) begin
    if (tx_done === 1'b1) txd_total <= txd_total + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int w;
    w = 0;
    while (cmd_ready !== 1'b1 && w < 40) begin
      tick();
      w++;
    end
    if (cmd_ready !== 1'b1) chk(tag, {63'd0, cmd_ready}, 64'd1);
  endtask

  // Issue a command, check the latched split against the model, then step into RUN.
  task automatic send_cmd(input logic [31:0] len, input logic fk);
    wait_ready("cmd_ready_wait");
    txd_base  = txd_total;
    mdl_c0    = fk ? (len - (len >> 1)) : len;
    mdl_c1    = fk ? (len >> 1) : 32'd0;
    cmd_valid = 1'b1;
    cmd_len   = len;
    cmd_fork  = fk;
    tick();
    cmd_valid = 1'b0;
    cmd_len   = 32'd0;
    cmd_fork  = 1'b0;
    chk("len_c0", {32'd0, len_c0}, {32'd0, mdl_c0});
    chk("len_c1", {32'd0, len_c1}, {32'd0, mdl_c1});
    chk("fork_enable", {63'd0, fork_enable}, {63'd0, fk});
    chk("ch_start", {63'd0, ch_start}, {63'd0, (len != 32'd0)});
    chk("cmd_ready_busy", {63'd0, cmd_ready}, 64'd0);
    if (len == 32'd0) begin
      chk("zero_txd", {63'd0, tx_done}, 64'd1);
    end else begin
      tick();
      chk("ch_start_pulse", {63'd0, ch_start}, 64'd0);
    end
  endtask

  task automatic sb_push(input int txd, input logic et, input logic ab,
                         input logic [31:0] c0, input logic [31:0] c1);
    exp_t e;
    e.txd         = txd;
    e.err_timeout = et;
    e.aborted     = ab;
    e.cnt0        = c0;
    e.cnt1        = c1;
    e.err_count   = (txd != 0) && ((c0 != mdl_c0) || (c1 != mdl_c1));
    sb_q.push_back(e);
  endtask

  task automatic drive_beats(input int n0, input int n1);
    int n;
    n = (n0 > n1) ? n0 : n1;
    for (int i = 0; i < n; i++) begin
      beat_c0 = (i < n0);
      beat_c1 = (i < n1);
      tick();
    end
    beat_c0 = 1'b0;
    beat_c1 = 1'b0;
  endtask

  task automatic pulse_done(input logic d0, input logic d1);
    done_c0 = d0;
    done_c1 = d1;
    tick();
    done_c0 = 1'b0;
    done_c1 = 1'b0;
  endtask

  // Wait for the job to retire and compare its end state with the scoreboard.
  task automatic finish_job(input string tag);
    exp_t e;
    wait_ready({tag, "_end_wait"});
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'd0, 64'd1);
    end else begin
      e = sb_q.pop_front();
      chk({tag, "_txd_pulses"}, 64'(txd_total - txd_base), 64'(e.txd));
      chk({tag, "_err_count"}, {63'd0, err_count}, {63'd0, e.err_count});
      chk({tag, "_err_timeout"}, {63'd0, err_timeout}, {63'd0, e.err_timeout});
      chk({tag, "_aborted"}, {63'd0, aborted}, {63'd0, e.aborted});
      chk({tag, "_cnt_c0"}, {32'd0, cnt_c0}, {32'd0, e.cnt0});
      chk({tag, "_cnt_c1"}, {32'd0, cnt_c1}, {32'd0, e.cnt1});
    end
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_len   = 32'd0;
    cmd_fork  = 1'b0;
    beat_c0   = 1'b0;
    beat_c1   = 1'b0;
    done_c0   = 1'b0;
    done_c1   = 1'b0;
    abort     = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    chk("rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_tx_done", {63'd0, tx_done}, 64'd0);
    chk("rst_len_c0", {32'd0, len_c0}, 64'd0);
    chk("rst_flags", {61'd0, err_timeout, err_count, aborted}, 64'd0);

    // Odd split, C1 finishes first with a repeated done.
    send_cmd(32'd7, 1'b1);
    sb_push(1, 1'b0, 1'b0, 32'd4, 32'd3);
    drive_beats(4, 3);
    pulse_done(1'b0, 1'b1);
    pulse_done(1'b0, 1'b1);
    chk("odd_busy", {63'd0, busy}, 64'd1);
    pulse_done(1'b1, 1'b0);
    chk("odd_txd", {63'd0, tx_done}, 64'd1);
    finish_job("odd");

    // No fork: C1 done never needed.
    send_cmd(32'd5, 1'b0);
    sb_push(1, 1'b0, 1'b0, 32'd5, 32'd0);
    drive_beats(5, 0);
    pulse_done(1'b1, 1'b0);
    chk("nofork_txd", {63'd0, tx_done}, 64'd1);
    finish_job("nofork");

    // Same-cycle dones at T+2 give tx_done at T+3, one pulse only.
    send_cmd(32'd2, 1'b1);
    sb_push(1, 1'b0, 1'b0, 32'd0, 32'd0);
    pulse_done(1'b1, 1'b1);
    chk("same_txd", {63'd0, tx_done}, 64'd1);
    tick();
    chk("same_txd_clr", {63'd0, tx_done}, 64'd0);
    finish_job("same");

    // Count mismatch.
    send_cmd(32'd4, 1'b1);
    sb_push(1, 1'b0, 1'b0, 32'd2, 32'd1);
    drive_beats(2, 1);
    pulse_done(1'b1, 1'b1);
    finish_job("mismatch");

    // Sparse activity keeps the watchdog from firing.
    send_cmd(32'd2, 1'b0);
    sb_push(1, 1'b0, 1'b0, 32'd2, 32'd0);
    repeat (12) tick();
    drive_beats(1, 0);
    repeat (12) tick();
    drive_beats(1, 0);
    repeat (12) tick();
    pulse_done(1'b1, 1'b0);
    finish_job("keepalive");

    // Timeout on the 16th idle RUN cycle.
    send_cmd(32'd2, 1'b1);
    sb_push(0, 1'b1, 1'b0, 32'd0, 32'd0);
    repeat (15) tick();
    chk("to_still_run", {63'd0, cmd_ready}, 64'd0);
    tick();
    chk("to_in_err", {63'd0, cmd_ready}, 64'd0);
    tick();
    chk("to_ready", {63'd0, cmd_ready}, 64'd1);
    finish_job("timeout");

    // Abort mid-RUN, then beats/dones in IDLE are ignored.
    send_cmd(32'd6, 1'b1);
    sb_push(0, 1'b0, 1'b1, 32'd1, 32'd1);
    drive_beats(1, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_ready", {63'd0, cmd_ready}, 64'd1);
    finish_job("abort");
    beat_c0 = 1'b1;
    done_c0 = 1'b1;
    tick();
    beat_c0 = 1'b0;
    done_c0 = 1'b0;
    chk("idle_cnt_c0", {32'd0, cnt_c0}, 64'd1);
    chk("idle_txd", {63'd0, tx_done}, 64'd0);

    // Zero-length job completes at T+1 without a start strobe.
    send_cmd(32'd0, 1'b1);
    sb_push(1, 1'b0, 1'b0, 32'd0, 32'd0);
    tick();
    chk("zero_ready", {63'd0, cmd_ready}, 64'd1);
    chk("zero_txd_clr", {63'd0, tx_done}, 64'd0);
    finish_job("zero");

    // Reset mid-RUN returns everything to reset values.
    send_cmd(32'd3, 1'b1);
    drive_beats(1, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    chk("mrst_busy", {63'd0, busy}, 64'd0);
    chk("mrst_fork", {63'd0, fork_enable}, 64'd0);
    chk("mrst_len_c0", {32'd0, len_c0}, 64'd0);
    chk("mrst_cnt_c0", {32'd0, cnt_c0}, 64'd0);
    chk("mrst_cnt_c1", {32'd0, cnt_c1}, 64'd0);
    tick();
    chk("mrst_no_txd", 64'(txd_total - txd_base), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/paicore_send_sched.md
Name: paicore_send_sched

Overview:
Job-level controller for the two-channel PAICORE send path (fifo -> fork -> C0/C1 senders).
- Accepts a send command over a valid/ready handshake.
- Splits the beat count across C0/C1 and drives fork enable and per-channel lengths.
- Counts beats issued per channel and merges the two per-channel done pulses into one job-done pulse.
- Watchdog aborts a stalled job; abort input cancels a job.

Parameters:
LEN_W, 32, width of lengths and beat counters
TO_W, 24, width of watchdog counter
TIMEOUT_CYCLES, 24'hFFFFFF, idle cycles (no beat, no done) before timeout

Ports:
s_axis_aclk  in  1  clock
rst  in  1  synchronous reset, active-high
cmd_valid  in  1  command valid
cmd_ready  out  1  command accept
cmd_len  in  LEN_W  total 64-bit beats for job
cmd_fork  in  1  1 = split across C0/C1, 0 = all beats to C0
fork_enable  out  1  to fork
len_c0  out  LEN_W  beats assigned to C0
len_c1  out  LEN_W  beats assigned to C1
ch_start  out  1  one-cycle start strobe to both senders
beat_c0  in  1  C0 input handshake (tvalid&tready)
beat_c1  in  1  C1 input handshake
done_c0  in  1  C0 tx-done pulse
done_c1  in  1  C1 tx-done pulse
abort  in  1  cancel current job
busy  out  1  state != IDLE
tx_done  out  1  one-cycle job-complete pulse
cnt_c0  out  LEN_W  beats seen on C0 this job
cnt_c1  out  LEN_W  beats seen on C1 this job
err_timeout  out  1  sticky: watchdog fired
err_count  out  1  sticky: beat count != assigned length at completion
aborted  out  1  sticky: job ended by abort

Behaviour:
- Reset: state=IDLE. All outputs 0 except cmd_ready=1.
- Registered outputs only; cmd_ready = (state==IDLE).
- IDLE, on cmd_valid&cmd_ready:
  - Latch fork_enable=cmd_fork.
  - cmd_fork=1: len_c0=(cmd_len+1)>>1 computed LEN_W+1 wide, len_c1=cmd_len>>1. Odd remainder goes to C0.
  - cmd_fork=0: len_c0=cmd_len, len_c1=0.
  - Clear the three sticky flags and both counters.
  - cmd_len==0 -> DONE; else -> START.
  - len_*/fork_enable are valid from the cycle after accept and hold until the next accept.
- START: ch_start=1 for exactly this cycle; watchdog cleared. Preset done_seen_c1=1 if len_c1==0 and done_seen_c0=1 if len_c0==0; other done_seen flags clear. Beats and dones in this cycle are ignored. -> RUN.
- RUN:
  - cnt_cX increments on beat_cX and saturates at all-ones.
  - done_cX sets done_seen_cX. Both may arrive in the same cycle, or in any order.
  - Watchdog: reset on any beat or done; otherwise increment. At TIMEOUT_CYCLES -> ERR.
  - When both done_seen flags are 1 (including the same-cycle case) -> DONE.
  - Priority within a cycle: abort > completion > timeout.
- DONE: tx_done=1 for one cycle. err_count <= (cnt_c0!=len_c0)|(cnt_c1!=len_c1). -> IDLE.
- ERR: err_timeout<=1, no tx_done. -> IDLE.
- abort in START/RUN: aborted<=1, no tx_done, -> IDLE next cycle. abort in IDLE or DONE is ignored.
- Ignored inputs: beat/done in IDLE and DONE do not change counters or flags. A repeated done_cX in RUN is idempotent.
- Latency: accept at T -> ch_start at T+1 -> earliest tx_done at T+3 (dones at T+2). Zero-length job: tx_done at T+1.
- rst mid-job: return to IDLE immediately, everything cleared, no tx_done.
- Back-to-back: next command is accepted the cycle after DONE/ERR/abort exit.

Decomposition:
- Package paicore_send_pkg holds:
  - state encoding (IDLE, START, RUN, DONE, ERR)
  - LEN_W default
  - the length-split function (len, fork) -> {len_c0, len_c1}
- One sub-module: send_watchdog (clear, tick, TIMEOUT_CYCLES compare, expired flag), reused per job.

Test Plan:
- Odd split: cmd_len=7, fork=1 -> len_c0=4, len_c1=3, ch_start at T+1. Drive 4/3 beats then done_c1 before done_c0 -> one tx_done pulse, err_count=0.
- No fork: cmd_len=5, fork=0 -> len_c1=0, fork_enable=0. Only done_c0 pulses -> tx_done; done_c1 is not required.
- Same-cycle done: done_c0 and done_c1 in the same RUN cycle -> tx_done exactly one cycle later, single pulse.
- Count mismatch: cmd_len=4, fork=1. Deliver 2 beats on C0 and 1 on C1, then both dones -> tx_done=1, err_count=1, cnt_c1=1.
- Timeout: TIMEOUT_CYCLES=16, cmd_len=2, no beats or dones -> ERR at the 16th idle RUN cycle. err_timeout=1, no tx_done, cmd_ready=1 next cycle.
- Abort/reset/zero: abort mid-RUN -> aborted=1, IDLE, no tx_done. rst mid-RUN -> all outputs at reset values. cmd_len=0 -> tx_done at T+1 with no ch_start.
